// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS CPU: fetch FSM states,
// the NOP encoding and the primary opcodes the decoder also uses.
package cpu_pkg;

  // Fetch unit sequencing: request a word, then hold it while it executes.
  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } fetch_state_t;

  // Instruction register contents after reset (sll $0,$0,0).
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Primary opcodes (instruction bits [31:26]) shared with the decoder.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function field for jr, used by the decoder to raise JumpReg.
  localparam logic [5:0] FUNCT_JR = 6'h08;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: jr > j/jal > taken branch > fall-through.
// Every add is 32-bit modulo, so the top of the address space wraps to 0.
module next_pc_logic (
  input  logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [15:0] imm16,
  input  logic [25:0] target_instr,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] reg_target;

  // Word offset sign-extended and scaled to bytes; the adder drops the carry.
  assign branch_offset = {{14{imm16[15]}}, imm16, 2'b00};
  assign branch_target = pc_plus4 + branch_offset;
  assign jump_target   = {pc_plus4[31:28], target_instr, 2'b00};
  // The register target is forced word-aligned; the low bits only flag an error.
  assign reg_target    = {jr_target[31:2], 2'b00};

  // Priority select of the redirect source, fall-through by default.
  // NOTE: every output of a combinational block gets a value on every path
  // (default first), otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    next_pc  = pc_plus4;
    misalign = 1'b0;
    if (jump_reg) begin
      next_pc  = reg_target;
      misalign = |jr_target[1:0];
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: PC register, one-word fetch handshake with the
// instruction memory, instruction hold register and next-PC sequencing.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        advance,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic [15:0] Imm16,
  input  logic [25:0] TargetInstr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_misaligned
);

  fetch_state_t state, state_next;
  logic         load_instr;
  logic         load_pc;
  logic [31:0]  next_pc;
  logic         misalign;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  next_pc_logic u_next_pc (
    .pc_plus4     (pc_plus4),
    .branch       (Branch),
    .zero         (Zero),
    .jump         (Jump),
    .jump_reg     (JumpReg),
    .imm16        (Imm16),
    .target_instr (TargetInstr),
    .jr_target    (jr_target),
    .next_pc      (next_pc),
    .misalign     (misalign)
  );

  // Handshake sequencing: request in FETCH, present the word in EXEC.
  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    load_instr  = 1'b0;
    load_pc     = 1'b0;
    unique case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          load_instr = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (advance) begin
          load_pc    = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // State, PC, instruction and sticky error registers; reset wins over everything,
  // so a response arriving during reset is dropped and fetch restarts at RESET_PC.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      instruction   <= NOP;
      pc_misaligned <= 1'b0;
    end else begin
      state <= state_next;
      if (load_instr) begin
        instruction <= imem_rdata;
      end
      if (load_pc) begin
        pc <= next_pc;
        if (misalign) begin
          pc_misaligned <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a
// randomized run, checked against an arithmetic model of the PC rules.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0040;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        advance;
  logic        Branch;
  logic        Zero;
  logic        Jump;
  logic        JumpReg;
  logic [15:0] Imm16;
  logic [25:0] TargetInstr;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_misaligned;

  int vectors    = 0;
  int miscompares = 0;

  // Reference state: where the PC should be, the last fetched word, sticky flag.
  logic [31:0] model_pc;
  logic [31:0] model_instr;
  logic        model_mis;

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .advance       (advance),
    .Branch        (Branch),
    .Zero          (Zero),
    .Jump          (Jump),
    .JumpReg       (JumpReg),
    .Imm16         (Imm16),
    .TargetInstr   (TargetInstr),
    .jr_target     (jr_target),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .pc_misaligned (pc_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    Branch      = 1'b0;
    Zero        = 1'b0;
    Jump        = 1'b0;
    JumpReg     = 1'b0;
    Imm16       = $urandom;
    TargetInstr = $urandom;
    jr_target   = $urandom;
  endtask

  // Full visible state in FETCH: request up, nothing valid, address = model PC.
  task automatic check_fetch_state(input string tag);
    check({tag, ".pc"},        pc,                  model_pc);
    check({tag, ".addr"},      imem_addr,           model_pc);
    check({tag, ".pc4"},       pc_plus4,            model_pc + 32'd4);
    check({tag, ".req"},       {31'd0, imem_req},   32'd1);
    check({tag, ".valid"},     {31'd0, instr_valid}, 32'd0);
    check({tag, ".mis"},       {31'd0, pc_misaligned}, {31'd0, model_mis});
  endtask

  task automatic do_reset(input string tag, input logic ready_during);
    reset      = 1'b1;
    imem_ready = ready_during;
    imem_rdata = $urandom;
    advance    = 1'b0;
    tick();
    reset      = 1'b0;
    imem_ready = 1'b0;
    model_pc    = RST_PC;
    model_instr = 32'h0;
    model_mis   = 1'b0;
    check_fetch_state(tag);
    check({tag, ".instr"}, instruction, 32'h0);
  endtask

  // Fetch one word after 'waits' cycles of imem_ready low.
  task automatic fetch(input string tag, input int waits);
    logic [31:0] word;
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      tick();
      check_fetch_state({tag, ".wait"});
    end
    word       = $urandom;
    imem_ready = 1'b1;
    imem_rdata = word;
    tick();
    imem_ready  = 1'b0;
    imem_rdata  = $urandom;
    model_instr = word;
    check({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, ".req"},   {31'd0, imem_req},    32'd0);
    check({tag, ".instr"}, instruction,          model_instr);
    check({tag, ".pc"},    pc,                   model_pc);
  endtask

  // Hold EXEC for 'hold' cycles (with stray ready pulses), then advance
  // with the given controls and check the redirected PC.
  task automatic exec_instr(input string tag, input int hold,
                            input logic br, input logic z, input logic j, input logic jrg,
                            input logic [15:0] imm, input logic [25:0] tgt,
                            input logic [31:0] jrt);
    logic [31:0] seq;
    logic [31:0] exp_pc;
    for (int i = 0; i < hold; i++) begin
      advance    = 1'b0;
      imem_ready = 1'($urandom);
      imem_rdata = $urandom;
      clear_ctrl();
      tick();
      check({tag, ".hold.instr"}, instruction,          model_instr);
      check({tag, ".hold.pc"},    pc,                   model_pc);
      check({tag, ".hold.valid"}, {31'd0, instr_valid}, 32'd1);
    end
    imem_ready  = 1'b0;
    advance     = 1'b1;
    Branch      = br;
    Zero        = z;
    Jump        = j;
    JumpReg     = jrg;
    Imm16       = imm;
    TargetInstr = tgt;
    jr_target   = jrt;
    seq = model_pc + 32'd4;
    if (jrg) begin
      exp_pc = jrt & 32'hFFFF_FFFC;
      if (jrt[1:0] != 2'b00) model_mis = 1'b1;
    end else if (j) begin
      exp_pc = (seq & 32'hF000_0000) | ({6'd0, tgt} * 32'd4);
    end else if (br && z) begin
      exp_pc = seq + 32'(int'($signed(imm)) * 4);
    end else begin
      exp_pc = seq;
    end
    tick();
    advance = 1'b0;
    clear_ctrl();
    model_pc = exp_pc;
    check_fetch_state(tag);
  endtask

  initial begin
    reset      = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'h0;
    advance    = 1'b0;
    clear_ctrl();
    model_pc    = RST_PC;
    model_instr = 32'h0;
    model_mis   = 1'b0;
    tick();

    // Reset with ready high throughout: address 0x40, word valid a cycle later.
    do_reset("rst", 1'b1);
    check("rst.pc_const", pc, 32'h0000_0040);

    // Sequential run: 0x40 -> 0x44 -> 0x48 -> 0x4C.
    for (int i = 0; i < 3; i++) begin
      fetch("seq.f", 0);
      exec_instr("seq.x", 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
    end
    check("seq.final", pc, 32'h0000_004C);

    // Jump to 0x100, then backwards branch taken (0xFC) and not taken (0x104).
    fetch("j100.f", 0);
    exec_instr("j100.x", 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0000040, 32'h0);
    fetch("beq.f", 0);
    exec_instr("beq.x", 0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFE, 26'h0, 32'h0);
    check("beq.taken", pc, 32'h0000_00FC);
    fetch("j100b.f", 0);
    exec_instr("j100b.x", 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0000040, 32'h0);
    fetch("bnt.f", 0);
    exec_instr("bnt.x", 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFE, 26'h0, 32'h0);
    check("bnt.fall", pc, 32'h0000_0104);

    // jr to 0x3000_0000, then a j keeps the upper nibble of pc+4.
    fetch("jr3.f", 0);
    exec_instr("jr3.x", 0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h3000_0000);
    fetch("jhi.f", 0);
    exec_instr("jhi.x", 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0000010, 32'h0);
    check("jhi.pc", pc, 32'h3000_0040);

    // Handshake: 5 wait cycles, then 4 stalled EXEC cycles with ready pulses.
    fetch("hs.f", 5);
    exec_instr("hs.x", 4, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);

    // Randomized run: mixed waits, stalls and aligned control transfers.
    for (int i = 0; i < 24; i++) begin
      int kind;
      kind = int'($urandom_range(0, 4));
      fetch("rnd.f", int'($urandom_range(0, 2)));
      exec_instr("rnd.x", int'($urandom_range(0, 2)),
                 kind == 1 || kind == 2, kind == 1 || (kind == 2 ? 1'b0 : 1'($urandom)),
                 kind == 3, kind == 4,
                 16'($urandom), 26'($urandom), $urandom & 32'hFFFF_FFFC);
    end
    check("rnd.mis", {31'd0, pc_misaligned}, 32'd0);

    // Wrap: jr to the last word, then fall-through wraps to 0.
    fetch("wrap.f0", 0);
    exec_instr("wrap.x0", 0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'hFFFF_FFFC);
    check("wrap.pc4", pc_plus4, 32'h0000_0000);
    fetch("wrap.f1", 0);
    exec_instr("wrap.x1", 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
    check("wrap.pc", pc, 32'h0000_0000);

    // JumpReg beats Jump; misaligned target sets the sticky flag.
    fetch("mis.f", 0);
    exec_instr("mis.x", 0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0004, 26'h0000100, 32'h0000_0203);
    check("mis.pc", pc, 32'h0000_0200);
    check("mis.flag", {31'd0, pc_misaligned}, 32'd1);
    fetch("mis2.f", 1);
    exec_instr("mis2.x", 1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
    check("mis2.flag", {31'd0, pc_misaligned}, 32'd1);

    // Reset mid-fetch with a response in the reset cycle: dropped.
    imem_ready = 1'b0;
    tick();
    do_reset("rstf", 1'b1);
    tick();
    check_fetch_state("rstf.after");

    // Reset while in EXEC abandons the held instruction.
    fetch("rste.f", 0);
    do_reset("rste", 1'b0);
    fetch("post.f", 0);
    exec_instr("post.x", 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
    check("post.pc", pc, 32'h0000_0044);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit for the MIPS single-cycle CPU. Holds the program counter, issues word fetches to instruction memory over a ready handshake, and presents the fetched 32-bit word to the instruction decoder. It computes the next PC from the decoder's Branch/Jump/JumpReg/Imm16/TargetInstr outputs and the ALU zero flag, and supplies PC+4 as the jal link value.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be word-aligned.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_addr  out  32  fetch address, always equal to pc
- imem_req  out  1  fetch request, high only in FETCH
- imem_ready  in  1  imem_rdata valid this cycle; honoured only when imem_req=1
- imem_rdata  in  32  instruction word from memory
- instruction  out  32  registered instruction to decoder
- instr_valid  out  1  instruction corresponds to pc and may be executed
- advance  in  1  datapath has completed the current instruction; sampled only when instr_valid=1
- Branch  in  1  decoder branch flag
- Zero  in  1  ALU condition; beq/bne polarity folded in by ALU control
- Jump  in  1  decoder j/jal flag
- JumpReg  in  1  decoder jr flag
- Imm16  in  16  branch offset in words
- TargetInstr  in  26  jump target field
- jr_target  in  32  register-file Da value for jr
- pc  out  32  current PC
- pc_plus4  out  32  pc+4, the jal link value
- pc_misaligned  out  1  sticky; set when a jr target has a nonzero value in bits [1:0]

## Operation
- FSM with two states: FETCH and EXEC.
- FETCH: imem_req=1 and instr_valid=0. On imem_ready=1, register imem_rdata into instruction and move to EXEC. Otherwise stay in FETCH indefinitely.
- EXEC: instr_valid=1, imem_req=0, and instruction is held stable. On advance=1, load pc with next_pc and move to FETCH. Otherwise hold. imem_ready is ignored in EXEC.
- next_pc priority, highest first:
  - JumpReg: {jr_target[31:2],2'b00}. If jr_target[1:0]≠0, set pc_misaligned.
  - Jump: {pc_plus4[31:28],TargetInstr,2'b00}.
  - Branch&Zero: pc_plus4 + ({{14{Imm16[15]}},Imm16,2'b00}).
  - Otherwise: pc_plus4.
- All adds are 32-bit modulo with carry discarded, so 32'hFFFF_FFFC+4 wraps to 0.
- Branch, Zero, Jump, JumpReg, Imm16, TargetInstr and jr_target are don't-care except in an EXEC cycle with advance=1.
- pc_misaligned is cleared only by reset.

## Timing
- Reset (any cycle, any state): next edge gives pc=RESET_PC, state=FETCH, instruction=32'h0, instr_valid=0, pc_misaligned=0. Combinational outputs follow: imem_req=1, imem_addr=RESET_PC, pc_plus4=RESET_PC+4.
- A memory response that arrives during reset is dropped. Any in-flight fetch is abandoned and restarts at RESET_PC.
- Fetch latency: with imem_ready in the first FETCH cycle, instr_valid=1 on the next cycle. Each wait cycle adds one.
- Minimum throughput is 2 cycles per instruction: FETCH, then EXEC with advance=1.
- pc changes only on the EXEC→FETCH edge and on reset. imem_addr changes in the same cycle as pc.
- Redirect has zero penalty: the FETCH following a taken branch or jump already uses the new address.

## Structure
- Shared package (cpu_pkg) holds:
  - state enum (FETCH, EXEC)
  - NOP constant 32'h0
  - the common opcode defines shared with the decoder
- Sub-module next_pc_logic is purely combinational: inputs pc_plus4 and the control/target inputs; outputs next_pc and misalign. The top level holds the FSM, the PC and instruction registers, and the sticky flag.

## Test plan
- Reset with RESET_PC=32'h0000_0040 and imem_ready tied high → imem_addr=0x40 on first post-reset cycle; instr_valid=1 the cycle after; instruction=imem_rdata.
- Sequential run: advance=1 with no control flags, three times → pc sequence 0x40, 0x44, 0x48, 0x4C.
- Branch: pc=0x100, Branch=1, Zero=1, Imm16=16'hFFFE → pc=0xFC. The same with Zero=0 → pc=0x104.
- Jump and jr:
  - pc=0x3000_0000, Jump=1, TargetInstr=26'h0000010 → pc=0x3000_0040.
  - JumpReg=1 and Jump=1 together, jr_target=0x203 → pc=0x200 and pc_misaligned=1, which holds until reset.
- Handshake: imem_ready low for 5 cycles → imem_req stays 1 and instr_valid stays 0. Then advance held 0 for 4 EXEC cycles → instruction and pc stay stable; imem_ready pulses during EXEC are ignored.
- Reset mid-fetch, with imem_ready=1 in the reset cycle → instr_valid=0 and pc=RESET_PC afterwards. Also check wrap: pc=0xFFFF_FFFC, advance → pc=0.
